// File: rtl/axis_weight_frame_builder_if.sv
// AXI4-Stream bundle shared by the DMA weight input and the rotator output.
interface axis_weight_frame_builder_if #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tkeep,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        input  tkeep,
        output tready
    );
endinterface

// File: rtl/axis_weight_frame_builder.sv
// Per-layer weight frame builder: one header beat with the packed layer config,
// then exactly cfg_beats_1+1 DMA weight beats, tlast on the final one.
// A DMA burst whose tlast disagrees with the programmed count raises err_len.
//
// state | meaning
// IDLE  | waiting for a layer config; the header is loaded on the config handshake
// DATA  | forwarding DMA weight beats until the remaining-beat counter hits zero
module axis_weight_frame_builder #(
    parameter int S_WIDTH     = 128,
    parameter int WORD_WIDTH  = 8,
    parameter int BITS_KW2    = 2,
    parameter int BITS_CIN    = 10,
    parameter int BITS_COLS   = 6,
    parameter int BITS_BLOCKS = 4,
    parameter int BITS_XN     = 8,
    parameter int BITS_ADDR   = 10,
    parameter int BITS_BEATS  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [BITS_KW2-1:0]    cfg_kw2_i,
    input  logic [BITS_CIN-1:0]    cfg_cin_1_i,
    input  logic [BITS_COLS-1:0]   cfg_cols_1_i,
    input  logic [BITS_BLOCKS-1:0] cfg_blocks_1_i,
    input  logic [BITS_XN-1:0]     cfg_xn_1_i,
    input  logic [BITS_ADDR-1:0]   cfg_addr_max_i,
    input  logic [BITS_BEATS-1:0]  cfg_beats_1_i,

    axis_weight_frame_builder_if.slave  s_axis,
    axis_weight_frame_builder_if.master m_axis,

    output logic                   err_len_o
);

    localparam int KEEP_W = S_WIDTH / WORD_WIDTH;
    localparam int HDR_W  = BITS_ADDR + BITS_XN + BITS_BLOCKS + BITS_COLS + BITS_CIN + BITS_KW2;
    localparam logic [BITS_BEATS-1:0] BEAT_ONE = BITS_BEATS'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [BITS_BEATS-1:0]  rem_q, rem_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic [S_WIDTH-1:0]     m_data_q, m_data_d;
    logic [KEEP_W-1:0]      m_keep_q, m_keep_d;
    logic                   err_len_q, err_len_d;

    logic                   load_ok;
    logic                   rem_zero;
    logic                   cfg_hs;
    logic                   s_hs;
    logic [S_WIDTH-1:0]     header;

    // The output stage may take a new beat when empty or being drained this cycle.
    assign load_ok  = !m_valid_q || m_axis.tready;
    assign rem_zero = (rem_q == '0);

    assign cfg_ready_o   = (state_q == IDLE) && load_ok;
    assign s_axis.tready = (state_q == DATA) && load_ok;

    assign cfg_hs = cfg_valid_i && cfg_ready_o;
    assign s_hs   = s_axis.tvalid && s_axis.tready;

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign err_len_o     = err_len_q;

    // Header word: config fields packed LSB-first from kw2, zero-extended to the bus.
    always_comb begin
        header = '0;
        header[HDR_W-1:0] = {cfg_addr_max_i, cfg_xn_1_i, cfg_blocks_1_i,
                             cfg_cols_1_i, cfg_cin_1_i, cfg_kw2_i};
    end

    // Next-state, beat counter, output stage and length-check decisions.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        err_len_d = err_len_q;

        if (cfg_hs) begin
            state_d   = DATA;
            rem_d     = cfg_beats_1_i;
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            m_data_d  = header;
            m_keep_d  = {KEEP_W{1'b1}};
        end else if (s_hs) begin
            m_valid_d = 1'b1;
            m_last_d  = rem_zero;
            m_data_d  = s_axis.tdata;
            m_keep_d  = s_axis.tkeep;
            // Framing follows rem only; the DMA tlast is just cross-checked.
            if (s_axis.tlast != rem_zero) begin
                err_len_d = 1'b1;
            end
            if (rem_zero) begin
                state_d = IDLE;
            end else begin
                rem_d = rem_q - BEAT_ONE;
            end
        end else if (m_axis.tready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            err_len_q <= err_len_d;
        end
    end

endmodule

// File: doc/axis_weight_frame_builder.md
# axis_weight_frame_builder

Builds the per-layer weight stream consumed by the weight rotator's `s_axis` port. It latches one layer's configuration from the control interface and emits a single header beat carrying the packed config word. It then passes exactly the programmed number of DMA weight beats through, generating `tlast` on the final beat. It sits between the weights DMA and the weight rotator and checks that the DMA burst length matches the configured beat count.

## Interface
Parameters:
- `S_WIDTH`, 128: data width of the DMA input and the output stream, in bits (= `S_WEIGHTS_WIDTH_LF`).
- `WORD_WIDTH`, 8: bits per keep lane. Keep width is `S_WIDTH/WORD_WIDTH`.
- `BITS_KW2`, 2: width of the `kw2` field.
- `BITS_CIN`, 10: width of the `cin_1` field.
- `BITS_COLS`, 6: width of the `cols_1` field.
- `BITS_BLOCKS`, 4: width of the `blocks_1` field.
- `BITS_XN`, 8: width of the `xn_1` field.
- `BITS_ADDR`, 10: width of the `addr_max` field.
- `BITS_BEATS`, 16: width of `cfg_beats_1`.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset: synchronous, active-low; clock `aclk`.
- `cfg_valid`  in  1  a layer config is presented.
- `cfg_ready`  out  1  config accepted when this and `cfg_valid` are both high.
- `cfg_kw2`, `cfg_cin_1`, `cfg_cols_1`, `cfg_blocks_1`, `cfg_xn_1`, `cfg_addr_max`  in  per-field width  layer configuration fields.
- `cfg_beats_1`  in  `BITS_BEATS`  number of weight beats minus 1.
- `s_axis_tvalid`, `s_axis_tlast`  in  1  DMA weight stream handshake and end of burst.
- `s_axis_tready`  out  1  DMA weight stream ready.
- `s_axis_tdata`  in  `S_WIDTH`  DMA weight data.
- `s_axis_tkeep`  in  `S_WIDTH/WORD_WIDTH`  DMA weight keep lanes.
- `m_axis_tvalid`, `m_axis_tlast`  out  1  stream to the rotator.
- `m_axis_tready`  in  1  rotator ready.
- `m_axis_tdata`  out  `S_WIDTH`  output data.
- `m_axis_tkeep`  out  `S_WIDTH/WORD_WIDTH`  output keep lanes.
- `err_len`  out  1  sticky burst-length mismatch flag.

## Operation
- State machine:
  - `IDLE`: on a config handshake, go to `DATA`.
  - `DATA`: on the final weight handshake, go back to `IDLE`.
- Output register:
  - Single stage holding `m_axis_*`.
  - `load_ok = !m_axis_tvalid || m_axis_tready`.
  - When loaded with nothing and `m_axis_tready` is high, `m_axis_tvalid` drops.
- `IDLE` behaviour:
  - `cfg_ready = load_ok`.
  - `s_axis_tready = 0`.
- On a config handshake:
  - Latch `cfg_beats_1` into the remaining-beat counter `rem`.
  - Load the header into the output register:
    - tdata = zero-extended `{addr_max, xn_1, blocks_1, cols_1, cin_1, kw2}`, with `kw2` at bit 0.
    - tkeep = all ones.
    - tlast = 0.
- `DATA` behaviour:
  - `cfg_ready = 0`.
  - `s_axis_tready = load_ok`.
  - On each s handshake, load `s_axis_tdata`/`tkeep` with `tlast = (rem == 0)`.
  - If `rem == 0`, go to `IDLE`; otherwise decrement `rem`.
- Length check:
  - On any `DATA` handshake where `s_axis_tlast != (rem == 0)`, set `err_len`.
  - `err_len` is cleared only by reset.
  - Framing is always governed by `rem`, never by `s_axis_tlast`.
- A frame has `cfg_beats_1 + 2` output beats (header plus weights).
- Back-to-back layers are supported: a new config may be accepted in the cycle after the last weight beat is loaded.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tkeep`, `err_len` = 0.
  - `s_axis_tready` = 0.
  - State = `IDLE`, `rem` = 0.
  - `cfg_ready` = 1 in the first cycle after reset deasserts.
- Latency: 1 cycle from an input handshake (cfg or s) to the beat appearing on `m_axis`.
- Throughput: 1 beat per cycle while `m_axis_tready` is held high.
  - Header and first weight beat are on consecutive cycles.
  - The final beat of frame N and the header of frame N+1 have at most a 1-cycle gap (the cycle in which `IDLE` samples cfg).
- The output register holds its value and `tvalid` stable while `m_axis_tready` is low (AXI-stream compliant). `s_axis_tready` and `cfg_ready` then stay low.
- Boundary cases:
  - `cfg_beats_1 = 0`: exactly one weight beat, with `tlast = 1`.
  - `cfg_beats_1 = 2^BITS_BEATS - 1`: a full count with no wrap; `rem` only decrements from nonzero.
- Reset mid-frame: in-flight data is discarded and all outputs return to their reset values on the next edge. The DMA must be reset with this block.
- `cfg_*` inputs are ignored outside `IDLE`; `s_axis_*` inputs are ignored in `IDLE`.

## Test plan
- Basic frame: cfg kw2=1, cin_1=3, cols_1=7, blocks_1=1, xn_1=0, addr_max=20, beats_1=3; 4 DMA beats with tlast on the 4th, `m_axis_tready` tied high.
  - Required: 5 output beats; header = 0x…`{20,0,1,7,3,1}` packed per field widths; tlast only on beat 5; `err_len` = 0.
- Backpressure: same frame with `m_axis_tready` toggling 1010… plus random `s_axis_tvalid` gaps.
  - Required: identical beat sequence; no beat dropped or duplicated; tdata/tvalid stable while stalled.
- Single beat: beats_1=0.
  - Required: header followed by one weight beat with tlast=1; `cfg_ready` high on the next cycle.
- Length mismatch: beats_1=3 with DMA tlast on beat 2.
  - Required: `err_len` rises on the beat-2 handshake and stays high; output tlast still on weight beat 4.
- Back-to-back frames: two configs queued (beats_1=1 and beats_1=2) with `m_axis_tready` high.
  - Required: 3 + 4 beats with at most a 1-cycle bubble between frames; second header carries the second config.
- Reset mid-frame: assert aresetn=0 after 2 of 4 weight beats.
  - Required: next cycle has `m_axis_tvalid`=0, `err_len`=0, `cfg_ready`=1; a fresh frame then completes correctly.
